// File: rtl/prf_stream_collector.sv
// Issues one prf_evaluate per index of a command and packs the returned symbols into FIFO-buffered words.
// Optional watchdog in WAIT: define PRF_STREAM_TIMEOUT_EN.
module prf_stream_collector #(
    parameter int P           = 32,
    parameter int WORD_WIDTH  = 64,
    parameter int CNT_WIDTH   = 32,
    parameter int FIFO_DEPTH  = 4,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [63:0]               cmd_nonce,
    input  logic [63:0]               cmd_index,
    input  logic [CNT_WIDTH-1:0]      cmd_count,
    output logic                      prf_start,
    output logic [63:0]               prf_nonce,
    output logic [63:0]               prf_index,
    input  logic [$clog2(P)-1:0]      prf_out,
    input  logic                      prf_done,
    output logic                      word_valid,
    input  logic                      word_ready,
    output logic [WORD_WIDTH-1:0]     word_data,
    output logic                      word_last,
    output logic                      busy,
    output logic                      err
);
    localparam int SW  = $clog2(P);
    localparam int SPW = WORD_WIDTH / SW;
    localparam int OW  = $clog2(WORD_WIDTH);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam logic [OW-1:0] LAST_OFF = OW'((SPW - 1) * SW);
    localparam logic [OW-1:0] SW_STEP  = OW'(SW);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t                state;
    logic [CNT_WIDTH-1:0]  remaining;
    logic [WORD_WIDTH-1:0] pack;
    logic [WORD_WIDTH-1:0] pack_nxt;
    logic [OW-1:0]         sym_off;
    logic [WORD_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] mem_last;
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [AW:0]           fill;
    logic                  take;
    logic                  last_sym;
    logic                  push;
    logic                  pop;
    logic                  full;
    logic                  timeout;

    assign full       = fill == (AW + 1)'(FIFO_DEPTH);
    assign take       = (state == WAIT) && prf_done;
    assign last_sym   = remaining == CNT_WIDTH'(1);
    assign push       = take && (last_sym || sym_off == LAST_OFF);
    assign word_valid = fill != '0;
    assign pop        = word_valid && word_ready;
    assign cmd_ready  = state == IDLE;
    assign prf_start  = (state == ISSUE) && !full;
    assign busy       = (state != IDLE) || word_valid;
    assign word_data  = word_valid ? mem[rd_ptr] : '0;
    assign word_last  = word_valid && mem_last[rd_ptr];

    always_comb begin
        pack_nxt = pack;
        pack_nxt[sym_off +: SW] = prf_out;
    end

`ifdef PRF_STREAM_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] tmo_cnt;
    logic          err_q;

    assign timeout = (state == WAIT) && !prf_done
                     && tmo_cnt == TW'(TIMEOUT_CYC - 1);
    assign err     = err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt <= '0;
            err_q   <= 1'b0;
        end else begin
            if (prf_start)
                tmo_cnt <= '0;
            else if (state == WAIT)
                tmo_cnt <= tmo_cnt + TW'(1);
            if (timeout)
                err_q <= 1'b1;
        end
    end
`else
    logic unused_tmo;
    assign unused_tmo = ^TIMEOUT_CYC;
    assign timeout    = 1'b0;
    assign err        = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            remaining <= '0;
            prf_nonce <= '0;
            prf_index <= '0;
            pack      <= '0;
            sym_off   <= '0;
        end else begin
            unique case (state)
                IDLE: if (cmd_valid) begin
                    remaining <= cmd_count;
                    prf_nonce <= cmd_nonce;
                    prf_index <= cmd_index;
                    if (cmd_count != '0)
                        state <= ISSUE;
                end
                ISSUE: if (!full)
                    state <= WAIT;
                WAIT: if (prf_done) begin
                    remaining <= remaining - CNT_WIDTH'(1);
                    prf_index <= prf_index + 64'd1;
                    state     <= last_sym ? IDLE : ISSUE;
                    if (push) begin
                        pack    <= '0;
                        sym_off <= '0;
                    end else begin
                        pack    <= pack_nxt;
                        sym_off <= sym_off + SW_STEP;
                    end
                end else if (timeout) begin
                    // partial word is dropped, no last word follows
                    state   <= IDLE;
                    pack    <= '0;
                    sym_off <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr]      <= pack_nxt;
            mem_last[wr_ptr] <= last_sym;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            fill <= fill + (AW + 1)'(push) - (AW + 1)'(pop);
        end
    end

endmodule

// File: tb/tb_prf_stream_collector.sv
// Randomized bench for prf_stream_collector with a PRF responder and a word-level reference model.
// Define PRF_STREAM_TIMEOUT_EN to also exercise the watchdog.
module tb_prf_stream_collector;
    localparam int SW  = 5;
    localparam int SPW = 12;

    typedef struct packed {
        logic [63:0] d;
        logic        l;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [63:0] cmd_nonce;
    logic [63:0] cmd_index;
    logic [31:0] cmd_count;
    logic        prf_start;
    logic [63:0] prf_nonce;
    logic [63:0] prf_index;
    logic [4:0]  prf_out;
    logic        prf_done;
    logic        word_valid;
    logic        word_ready;
    logic [63:0] word_data;
    logic        word_last;
    logic        busy;
    logic        err;

    always #5 clk = ~clk;

    prf_stream_collector #(.TIMEOUT_CYC(16)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_nonce(cmd_nonce), .cmd_index(cmd_index), .cmd_count(cmd_count),
        .prf_start(prf_start), .prf_nonce(prf_nonce), .prf_index(prf_index),
        .prf_out(prf_out), .prf_done(prf_done),
        .word_valid(word_valid), .word_ready(word_ready),
        .word_data(word_data), .word_last(word_last),
        .busy(busy), .err(err)
    );

    int n_checks = 0;
    int n_errors = 0;

    // reference model of the current command
    logic [63:0] cur_nonce, cur_idx, acc;
    int          cur_left, acc_k;
    exp_t        exp_q[$];

    // responder / consumer controls and observations
    bit          pend, resp_en, spur_en, fix_sym_en, start_now;
    int          dly, fix_delay, ready_mode;
    logic [4:0]  fix_sym;
    int          n_starts, n_words;
    logic [63:0] first_data, last_data;
    logic        last_flag;

    task automatic check_eq(input string tag, input logic [63:0] got,
                            input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void model_take(input logic [4:0] s);
        acc = acc | (64'(s) << (acc_k * SW));
        acc_k++;
        cur_left--;
        cur_idx = cur_idx + 64'd1;
        if (acc_k == SPW || cur_left == 0) begin
            exp_q.push_back('{d: acc, l: (cur_left == 0)});
            acc   = '0;
            acc_k = 0;
        end
    endfunction

    function automatic void model_clear();
        exp_q.delete();
        acc      = '0;
        acc_k    = 0;
        cur_left = 0;
        pend     = 1'b0;
    endfunction

    task automatic tick();
        exp_t       e;
        logic [4:0] s;
        @(negedge clk);
        start_now  = prf_start;
        word_ready = (ready_mode == 2) ? 1'($urandom) : (ready_mode != 0);
        if (word_valid && word_ready) begin
            if (exp_q.size() == 0) begin
                check_eq("extra_word", 64'(word_data), 64'h0);
            end else begin
                e = exp_q.pop_front();
                check_eq("word_data", word_data, e.d);
                check_eq("word_last", 64'(word_last), 64'(e.l));
                if (n_words == 0)
                    first_data = word_data;
                n_words++;
                last_data = word_data;
                last_flag = word_last;
            end
        end
        prf_done = 1'b0;
        if (prf_start) begin
            check_eq("one_outstanding", 64'(pend), 64'h0);
            check_eq("prf_nonce", prf_nonce, cur_nonce);
            check_eq("prf_index", prf_index, cur_idx);
            n_starts++;
            pend = resp_en;
            dly  = (fix_delay > 0) ? fix_delay : int'($urandom_range(1, 4));
        end else if (pend) begin
            dly--;
            if (dly == 0) begin
                pend     = 1'b0;
                s        = fix_sym_en ? fix_sym : 5'($urandom);
                prf_out  = s;
                prf_done = 1'b1;
                model_take(s);
            end
        end else if (spur_en && cmd_ready && $urandom_range(0, 7) == 0) begin
            prf_out  = 5'($urandom);
            prf_done = 1'b1;
        end
    endtask

    task automatic send_cmd(input logic [63:0] n, input logic [63:0] i,
                            input int c);
        int b = 0;
        while (!cmd_ready && b < 2000) begin
            tick();
            b++;
        end
        if (!cmd_ready)
            check_eq("cmd_ready_wait", 64'(cmd_ready), 64'h1);
        cmd_valid = 1'b1;
        cmd_nonce = n;
        cmd_index = i;
        cmd_count = 32'(c);
        cur_nonce = n;
        cur_idx   = i;
        cur_left  = c;
        acc       = '0;
        acc_k     = 0;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int b = 0;
        while ((busy || pend || exp_q.size() != 0) && b < budget) begin
            tick();
            b++;
        end
        if (b >= budget)
            check_eq(tag, 64'(busy), 64'h0);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int b, c, tot_s, tot_w;
        rst = 1'b1;
        cmd_valid = 1'b0;
        cmd_nonce = '0;
        cmd_index = '0;
        cmd_count = '0;
        prf_out = '0;
        prf_done = 1'b0;
        word_ready = 1'b0;
        ready_mode = 0;
        resp_en = 1'b1;
        spur_en = 1'b0;
        fix_delay = 0;
        fix_sym_en = 1'b0;
        fix_sym = '0;
        n_starts = 0;
        n_words = 0;
        cur_nonce = '0;
        cur_idx = '0;
        model_clear();
        repeat (3) tick();
        check_eq("rst_cmd_ready", 64'(cmd_ready), 64'h1);
        check_eq("rst_prf_start", 64'(prf_start), 64'h0);
        check_eq("rst_word_valid", 64'(word_valid), 64'h0);
        check_eq("rst_word_data", word_data, 64'h0);
        check_eq("rst_word_last", 64'(word_last), 64'h0);
        check_eq("rst_busy", 64'(busy), 64'h0);
        check_eq("rst_err", 64'(err), 64'h0);
        check_eq("rst_prf_index", prf_index, 64'h0);
        rst = 1'b0;
        tick();

        // full single word of all-ones symbols
        ready_mode = 1;
        fix_delay = 3;
        fix_sym_en = 1'b1;
        fix_sym = 5'h1F;
        n_starts = 0;
        n_words = 0;
        send_cmd(64'hA5A5_0000_1234_5678, 64'd100, 12);
        check_eq("t1_start_latency", 64'(start_now), 64'h1);
        wait_idle("t1_drain", 500);
        check_eq("t1_starts", 64'(n_starts), 64'd12);
        check_eq("t1_words", 64'(n_words), 64'd1);
        check_eq("t1_data", last_data, 64'h0FFF_FFFF_FFFF_FFFF);
        check_eq("t1_last", 64'(last_flag), 64'h1);

        // one symbol past a word boundary
        fix_sym = 5'h01;
        fix_delay = 0;
        n_starts = 0;
        n_words = 0;
        send_cmd(64'h1, 64'd7, 13);
        wait_idle("t2_drain", 500);
        check_eq("t2_words", 64'(n_words), 64'd2);
        check_eq("t2_first", first_data, 64'h0084_2108_4210_8421);
        check_eq("t2_second", last_data, 64'h1);

        // empty command
        n_starts = 0;
        n_words = 0;
        send_cmd(64'h2, 64'h3, 0);
        check_eq("t3_cmd_ready", 64'(cmd_ready), 64'h1);
        check_eq("t3_no_start", 64'(start_now), 64'h0);
        repeat (5) tick();
        check_eq("t3_starts", 64'(n_starts), 64'd0);
        check_eq("t3_word_valid", 64'(word_valid), 64'h0);

        // back-pressure stall with a full FIFO
        ready_mode = 0;
        fix_delay = 1;
        fix_sym_en = 1'b0;
        n_starts = 0;
        n_words = 0;
        send_cmd(64'h55, 64'h1000, 60);
        repeat (300) tick();
        check_eq("t4_stall_starts", 64'(n_starts), 64'd48);
        check_eq("t4_word_valid", 64'(word_valid), 64'h1);
        check_eq("t4_busy", 64'(busy), 64'h1);
        ready_mode = 1;
        wait_idle("t4_drain", 1000);
        check_eq("t4_words", 64'(n_words), 64'd5);
        check_eq("t4_starts", 64'(n_starts), 64'd60);
        check_eq("t4_last", 64'(last_flag), 64'h1);

        // index wrap
        fix_delay = 0;
        n_starts = 0;
        send_cmd(64'h9, 64'hFFFF_FFFF_FFFF_FFFF, 2);
        wait_idle("t5_drain", 200);
        check_eq("t5_starts", 64'(n_starts), 64'd2);

        // reset in WAIT with a late done and a word still queued
        ready_mode = 0;
        fix_delay = 4;
        n_starts = 0;
        n_words = 0;
        send_cmd(64'h77, 64'h40, 20);
        b = 0;
        while (!(start_now && n_starts == 15) && b < 400) begin
            tick();
            b++;
        end
        check_eq("t6_reach_start", 64'(n_starts), 64'd15);
        pend = 1'b0;
        tick();
        check_eq("t6_queued_word", 64'(word_valid), 64'h1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        prf_out = 5'h1F;
        prf_done = 1'b1;
        tick();
        model_clear();
        repeat (3) tick();
        check_eq("t6_cmd_ready", 64'(cmd_ready), 64'h1);
        check_eq("t6_word_valid", 64'(word_valid), 64'h0);
        check_eq("t6_busy", 64'(busy), 64'h0);
        check_eq("t6_err", 64'(err), 64'h0);
        check_eq("t6_prf_index", prf_index, 64'h0);
        ready_mode = 1;
        repeat (5) tick();
        check_eq("t6_no_words", 64'(n_words), 64'd0);

`ifdef PRF_STREAM_TIMEOUT_EN
        resp_en = 1'b0;
        send_cmd(64'hDD, 64'h0, 3);
        repeat (16) tick();
        check_eq("to_err_early", 64'(err), 64'h0);
        tick();
        check_eq("to_err", 64'(err), 64'h1);
        check_eq("to_idle", 64'(cmd_ready), 64'h1);
        check_eq("to_no_word", 64'(word_valid), 64'h0);
        model_clear();
        resp_en = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        check_eq("to_err_cleared", 64'(err), 64'h0);
`endif

        // randomized back-to-back commands with spurious dones
        spur_en = 1'b1;
        fix_delay = 0;
        ready_mode = 2;
        n_starts = 0;
        n_words = 0;
        tot_s = 0;
        tot_w = 0;
        for (int k = 0; k < 40; k++) begin
            c = int'($urandom_range(0, 30));
            send_cmd({$urandom, $urandom}, {$urandom, $urandom}, c);
            tot_s += c;
            tot_w += (c + SPW - 1) / SPW;
        end
        wait_idle("rand_drain", 5000);
        check_eq("rand_starts", 64'(n_starts), 64'(tot_s));
        check_eq("rand_words", 64'(n_words), 64'(tot_w));
        check_eq("rand_err", 64'(err), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
